tournament_chooser: RTL
=======================

// Module: tournament_chooser
// PURPOSE
//  Choice stage of the tournament branch predictor. It sits downstream of the local and global predictors.
//  - Picks one of their two predictions using a table of 2-bit choice counters, indexed by global history (GHR).
//  - Keeps an in-order queue of in-flight predictions; each is retired when BranchTaken resolves.
//  - On resolve: trains the chooser, repairs the GHR after a mispredict, and flushes younger wrong-path entries.
// PARAMETERS
//  GHR_W     12  global history bits; choice table has 2**GHR_W entries
//  PC_W      10  width of PC, carried for debug/tag
//  Q_DEPTH   4   in-flight prediction queue depth (power of 2)
//  CNT_W     16  width of saturating mispredict counter
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       asynchronous, active-low reset
//  pred_valid      in   1       new branch presented this cycle
//  pred_ready      out  1       chooser can accept a prediction
//  PC              in   PC_W    branch PC (stored in queue entry)
//  LocalPred       in   1       local predictor BranchResult
//  GlobalPred      in   1       global predictor prediction
//  FinalPred       out  1       chosen prediction (combinational)
//  resolve_valid   in   1       oldest in-flight branch resolved this cycle
//  BranchTaken     in   1       actual outcome of oldest branch
//  mispredict      out  1       resolve_valid & (BranchTaken != head.final)
//  resolve_pc      out  PC_W    PC of queue head
//  ghr             out  GHR_W   current speculative global history
//  mispredict_cnt  out  CNT_W   saturating count of mispredicts
//  underflow_err   out  1       sticky: resolve seen with empty queue
// BEHAVIOUR
//  Reset (async, reset==0)
//   - Every choice counter = 2'b01 (weakly local); ghr = 0; queue empty.
//   - mispredict_cnt = 0; underflow_err = 0; pred_ready = 1 once reset is released.
//   - Reset asserted mid-operation discards all in-flight entries immediately.
//  Predict path
//   - ctr = choice[ghr]; FinalPred = ctr[1] ? GlobalPred : LocalPred. Combinational, zero latency.
//   - Accept when pred_valid & pred_ready. At the clock edge, push {PC, ghr, LocalPred, GlobalPred, FinalPred}.
//   - Speculative update: ghr <= {ghr[GHR_W-2:0], FinalPred}.
//   - pred_ready = !full & !(resolve_valid & mispredict).
//   - Full queue (Q_DEPTH entries): the prediction is not accepted; ghr is unchanged.
//  Resolve path (head entry h, only if queue non-empty)
//   - Pop h every resolve_valid.
//   - Train only if h.local != h.global:
//       choice[h.ghr] += 1 when the global prediction was correct (sat 3);
//       choice[h.ghr] -= 1 when the local prediction was correct (sat 0).
//   - Correct prediction: ghr keeps its speculative value.
//   - Mispredict: flush all younger entries (queue empty after the edge); ghr <= {h.ghr[GHR_W-2:0], BranchTaken}.
//   - mispredict_cnt += 1 per mispredict, saturating at all-ones.
//  Simultaneous predict + resolve
//   - No mispredict: pop and push in the same edge, so occupancy is unchanged.
//     Allowed when full: pred_ready uses the pre-pop full flag and stays 0; the bench must not rely on same-cycle refill.
//   - Mispredict: the new prediction is refused (pred_ready=0); the resolve takes priority.
//   - The table read for FinalPred sees pre-update values. Same-index train/read returns the old counter.
//  Empty queue + resolve_valid: no state change except underflow_err <= 1 (sticky until reset).
//   - mispredict = 0; resolve_pc = 0.
//  Queue pointers wrap modulo Q_DEPTH. The occupancy counter is log2(Q_DEPTH)+1 bits.
// TESTING
//  1 Reset, then pred PC=30 L=1 G=0 -> FinalPred=1 (ctr 01), ghr=12'h001 next cycle, pred_ready=1.
//  2 Four preds without resolve (Q_DEPTH=4) -> pred_ready=0 on the 5th; ghr holds; resolve all correct -> queue empty, cnt=0.
//  3 Pred L=1 G=0 at ghr=0, resolve BranchTaken=0 -> mispredict=1, choice[0]=10, ghr=12'h000, cnt=1.
//    Next pred at ghr=0 with L=1 G=0 -> FinalPred=0.
//  4 Three in flight, head mispredicts while pred_valid=1 -> queue flushed, new pred refused.
//    ghr = head.ghr<<1|actual; next cycle pred_ready=1.
//  5 resolve_valid with empty queue -> underflow_err=1 and stays 1; other state unchanged.
//    Assert reset low mid-burst -> all counters back to 01, queue empty.
//  6 Repeated global-correct training at one index -> counter saturates at 11 and does not wrap.
//    L==G resolves leave the counter untouched.

Source files
------------

// File: rtl/tournament_chooser.sv
// Tournament chooser: selects local or global prediction per a GHR-indexed
// table of 2-bit choice counters and retires in-flight predictions in order.
module tournament_chooser #(
  parameter int GHR_W   = 12,
  parameter int PC_W    = 10,
  parameter int Q_DEPTH = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  PC,
  input  logic             LocalPred,
  input  logic             GlobalPred,
  output logic             FinalPred,
  input  logic             resolve_valid,
  input  logic             BranchTaken,
  output logic             mispredict,
  output logic [PC_W-1:0]  resolve_pc,
  output logic [GHR_W-1:0] ghr,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             underflow_err
);

  localparam int TN = 1 << GHR_W;
  localparam int QA = $clog2(Q_DEPTH);
  localparam logic [QA:0] FULL_N = (QA+1)'(Q_DEPTH);

  logic [1:0]       choice [TN];
  logic [PC_W-1:0]  q_pc   [Q_DEPTH];
  logic [GHR_W-1:0] q_ghr  [Q_DEPTH];
  logic             q_loc  [Q_DEPTH];
  logic             q_glb  [Q_DEPTH];
  logic             q_fin  [Q_DEPTH];

  logic [QA-1:0] head;
  logic [QA-1:0] tail;
  logic [QA:0]   count;

  logic             empty;
  logic             full;
  logic             do_res;
  logic             push;
  logic             train;
  logic [1:0]       hctr;
  logic [GHR_W-1:0] h_ghr;

  assign empty  = (count == '0);
  assign full   = (count == FULL_N);
  assign do_res = resolve_valid & ~empty;
  assign h_ghr  = q_ghr[head];
  assign hctr   = choice[h_ghr];
  assign train  = do_res & (q_loc[head] != q_glb[head]);

  assign FinalPred  = choice[ghr][1] ? GlobalPred : LocalPred;
  assign mispredict = do_res & (BranchTaken != q_fin[head]);
  assign resolve_pc = empty ? '0 : q_pc[head];
  assign pred_ready = ~full & ~mispredict;
  assign push       = pred_valid & pred_ready;

  // Counter moves toward whichever predictor matched the outcome
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TN; i++) choice[i] <= 2'b01;
    end else if (train) begin
      if (q_glb[head] == BranchTaken) begin
        if (hctr != 2'b11) choice[h_ghr] <= hctr + 2'b01;
      end else begin
        if (hctr != 2'b00) choice[h_ghr] <= hctr - 2'b01;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[tail]  <= PC;
      q_ghr[tail] <= ghr;
      q_loc[tail] <= LocalPred;
      q_glb[tail] <= GlobalPred;
      q_fin[tail] <= FinalPred;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ghr   <= '0;
    end else if (mispredict) begin
      head  <= head + QA'(1);
      tail  <= head + QA'(1);
      count <= '0;
      ghr   <= {h_ghr[GHR_W-2:0], BranchTaken};
    end else begin
      if (push) begin
        tail <= tail + QA'(1);
        ghr  <= {ghr[GHR_W-2:0], FinalPred};
      end
      if (do_res) head <= head + QA'(1);
      case ({push, do_res})
        2'b10:   count <= count + (QA+1)'(1);
        2'b01:   count <= count - (QA+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispredict_cnt <= '0;
      underflow_err  <= 1'b0;
    end else begin
      if (mispredict && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      if (resolve_valid && empty)
        underflow_err <= 1'b1;
    end
  end

endmodule
